// File: rtl/kronos_lsu_split.sv
// kronos_lsu_split: load/store unit front end that turns one decoded
// memory request into one or two word-aligned bus transactions.
//
// A request whose bytes straddle a word boundary is either split into two
// transactions (MISALIGNED_EN=1) or rejected with a misaligned pulse
// (MISALIGNED_EN=0). Load bytes from both transactions are merged in a
// 64-bit buffer, shifted down by the byte offset and sign/zero extended.
// An optional timeout (TIMEOUT>0) aborts a transaction whose ack never comes.
//
// Handshakes:
//   decode side: a request is taken on a cycle where decode_vld, decode_rdy
//     and (decode_load | decode_store) are all high; decode_rdy is high only
//     in IDLE.
//   bus side: data_req is held with address, mask and data stable until
//     data_ack is sampled high on a rising clk edge; data_ack while data_req
//     is low is ignored.
//
// Ports:
//   clk, rstz                    clock, asynchronous active-low reset
//   decode_addr/wdata/size/...   decoded request and its valid/ready
//   load_data, regwr_lsu         extended load result and its 1-cycle strobe
//   lsu_done, misaligned, bus_err completion / reject / timeout pulses
//   data_*                       word-aligned memory bus
//   state_dbg                    current FSM state (IDLE=0 REQ0=1 REQ1=2 DONE=3)
module kronos_lsu_split #(
    parameter int MISALIGNED_EN = 1,
    parameter int TIMEOUT       = 0
) (
    input  logic        clk,
    input  logic        rstz,
    input  logic [31:0] decode_addr,
    input  logic [31:0] decode_wdata,
    input  logic [1:0]  decode_size,
    input  logic        decode_unsigned,
    input  logic        decode_load,
    input  logic        decode_store,
    input  logic        decode_vld,
    output logic        decode_rdy,
    output logic [31:0] load_data,
    output logic        regwr_lsu,
    output logic        lsu_done,
    output logic        misaligned,
    output logic        bus_err,
    output logic [31:0] data_addr,
    output logic [31:0] data_wr_data,
    output logic [3:0]  data_mask,
    output logic        data_wr_en,
    output logic        data_req,
    input  logic [31:0] data_rd_data,
    input  logic        data_ack,
    output logic [1:0]  state_dbg
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ0 = 2'd1;
    localparam logic [1:0] REQ1 = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]  state;
    logic        started;   // low until the first clock after reset release
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic        load_q;
    logic        store_q;
    logic        split_q;
    logic        err_q;
    logic        req_q;
    logic        mis_q;
    logic [63:0] buf_q;
    logic [31:0] ld_hold;
    logic [31:0] tmo_cnt;

    // Request classification on the decode inputs
    logic [2:0] bytes_in;
    logic       misal_in;
    logic       accept;

    always_comb begin
        case (decode_size)
            2'd0:    bytes_in = 3'd1;
            2'd1:    bytes_in = 3'd2;
            default: bytes_in = 3'd4;
        endcase
    end

    assign misal_in   = ({1'b0, decode_addr[1:0]} + bytes_in) > 3'd4;
    assign decode_rdy = (state == IDLE) && started;
    assign accept     = decode_rdy && decode_vld && (decode_load || decode_store);

    // Byte lanes and write data spread over a two-word window; REQ0 uses the
    // low word, REQ1 the high word.
    logic [3:0]  bytemask;
    logic [7:0]  mask8;
    logic [63:0] wide_wdata;
    logic [4:0]  bit_off;

    always_comb begin
        case (size_q)
            2'd0:    bytemask = 4'h1;
            2'd1:    bytemask = 4'h3;
            default: bytemask = 4'hF;
        endcase
    end

    assign bit_off    = {addr_q[1:0], 3'b000};
    assign mask8      = {4'h0, bytemask} << addr_q[1:0];
    assign wide_wdata = {32'h0, wdata_q} << bit_off;

    logic [31:0] word_addr;
    logic        in_req;

    assign word_addr    = {addr_q[31:2], 2'b00};
    assign in_req       = (state == REQ0) || (state == REQ1);
    assign data_req     = req_q;
    assign data_wr_en   = in_req && store_q;
    assign data_addr    = (state == REQ0) ? word_addr :
                          (state == REQ1) ? word_addr + 32'd4 : 32'h0;
    assign data_mask    = (state == REQ0) ? mask8[3:0] :
                          (state == REQ1) ? mask8[7:4] : 4'h0;
    assign data_wr_data = (state == REQ0) ? wide_wdata[31:0] :
                          (state == REQ1) ? wide_wdata[63:32] : 32'h0;

    // An ack only counts while a request is actually on the bus
    logic ack_ok;
    logic tmo_hit;

    assign ack_ok  = req_q && data_ack;
    assign tmo_hit = (TIMEOUT > 0) && req_q && !data_ack &&
                     (tmo_cnt == 32'(TIMEOUT - 1));

    // Load result: shift merged buffer down to the addressed byte, extend
    logic [63:0] shifted;
    logic [31:0] ld_word;
    logic [31:0] ld_result;

    assign shifted = buf_q >> bit_off;
    assign ld_word = shifted[31:0];

    always_comb begin
        case (size_q)
            2'd0:    ld_result = uns_q ? {24'h0, ld_word[7:0]}
                                       : {{24{ld_word[7]}}, ld_word[7:0]};
            2'd1:    ld_result = uns_q ? {16'h0, ld_word[15:0]}
                                       : {{16{ld_word[15]}}, ld_word[15:0]};
            default: ld_result = ld_word;
        endcase
    end

    assign lsu_done   = (state == DONE);
    assign regwr_lsu  = (state == DONE) && load_q && !err_q;
    assign bus_err    = (state == DONE) && err_q;
    assign misaligned = mis_q;
    assign load_data  = regwr_lsu ? ld_result : ld_hold;
    assign state_dbg  = state;

    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            state   <= IDLE;
            started <= 1'b0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            size_q  <= 2'd0;
            uns_q   <= 1'b0;
            load_q  <= 1'b0;
            store_q <= 1'b0;
            split_q <= 1'b0;
            err_q   <= 1'b0;
            req_q   <= 1'b0;
            mis_q   <= 1'b0;
            buf_q   <= 64'h0;
            ld_hold <= 32'h0;
            tmo_cnt <= 32'h0;
        end else begin
            started <= 1'b1;
            mis_q   <= accept && misal_in && (MISALIGNED_EN == 0);
            if (req_q && !data_ack) begin
                tmo_cnt <= tmo_cnt + 32'd1;
            end
            case (state)
                IDLE: begin
                    if (accept) begin
                        addr_q  <= decode_addr;
                        wdata_q <= decode_wdata;
                        size_q  <= decode_size;
                        uns_q   <= decode_unsigned;
                        load_q  <= decode_load;
                        store_q <= decode_store;
                        err_q   <= 1'b0;
                        split_q <= misal_in;
                        if (!(misal_in && (MISALIGNED_EN == 0))) begin
                            state   <= REQ0;
                            req_q   <= 1'b1;
                            tmo_cnt <= 32'h0;
                        end
                    end
                end
                REQ0: begin
                    if (ack_ok) begin
                        buf_q[31:0] <= data_rd_data;
                        req_q       <= 1'b0;
                        state       <= split_q ? REQ1 : DONE;
                    end else if (tmo_hit) begin
                        req_q <= 1'b0;
                        err_q <= 1'b1;
                        state <= DONE;
                    end
                end
                REQ1: begin
                    // First REQ1 cycle keeps data_req low to separate the two
                    // transactions, then the second request goes out.
                    if (!req_q) begin
                        req_q   <= 1'b1;
                        tmo_cnt <= 32'h0;
                    end else if (ack_ok) begin
                        buf_q[63:32] <= data_rd_data;
                        req_q        <= 1'b0;
                        state        <= DONE;
                    end else if (tmo_hit) begin
                        req_q <= 1'b0;
                        err_q <= 1'b1;
                        state <= DONE;
                    end
                end
                default: begin
                    if (load_q && !err_q) begin
                        ld_hold <= ld_result;
                    end
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_kronos_lsu_split.sv
// Bench for kronos_lsu_split: table of directed load/store vectors against a
// small word memory with configurable ack latency, plus hand-written
// sequences for reset, timeout, ignored and rejected misaligned requests.
module tb_kronos_lsu_split;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rstz = 1'b0;

    // ---------------- DUT signals ----------------
    logic [31:0] decode_addr = 32'h0;
    logic [31:0] decode_wdata = 32'h0;
    logic [1:0]  decode_size = 2'd0;
    logic        decode_unsigned = 1'b0;
    logic        decode_load = 1'b0;
    logic        decode_store = 1'b0;
    logic        decode_vld = 1'b0;
    logic        decode_rdy;
    logic [31:0] load_data;
    logic        regwr_lsu, lsu_done, misaligned, bus_err;
    logic [31:0] data_addr, data_wr_data;
    logic [3:0]  data_mask;
    logic        data_wr_en, data_req;
    logic [31:0] data_rd_data = 32'h0;
    logic        data_ack = 1'b0;
    logic [1:0]  state_dbg;

    kronos_lsu_split #(.MISALIGNED_EN(1), .TIMEOUT(4)) u_dut (
        .clk(clk), .rstz(rstz),
        .decode_addr(decode_addr), .decode_wdata(decode_wdata),
        .decode_size(decode_size), .decode_unsigned(decode_unsigned),
        .decode_load(decode_load), .decode_store(decode_store),
        .decode_vld(decode_vld), .decode_rdy(decode_rdy),
        .load_data(load_data), .regwr_lsu(regwr_lsu), .lsu_done(lsu_done),
        .misaligned(misaligned), .bus_err(bus_err),
        .data_addr(data_addr), .data_wr_data(data_wr_data), .data_mask(data_mask),
        .data_wr_en(data_wr_en), .data_req(data_req),
        .data_rd_data(data_rd_data), .data_ack(data_ack), .state_dbg(state_dbg)
    );

    // Second instance with splitting disabled; its bus never acks.
    logic        vld_na = 1'b0;
    logic        rdy_na, regwr_na, done_na, mis_na, err_na, wr_en_na, req_na;
    logic [31:0] ld_na, addr_na, wd_na;
    logic [3:0]  mask_na;
    logic [31:0] rd_na = 32'h0;
    logic        ack_na = 1'b0;
    logic [1:0]  state_na;

    kronos_lsu_split #(.MISALIGNED_EN(0), .TIMEOUT(0)) u_na (
        .clk(clk), .rstz(rstz),
        .decode_addr(decode_addr), .decode_wdata(decode_wdata),
        .decode_size(decode_size), .decode_unsigned(decode_unsigned),
        .decode_load(decode_load), .decode_store(decode_store),
        .decode_vld(vld_na), .decode_rdy(rdy_na),
        .load_data(ld_na), .regwr_lsu(regwr_na), .lsu_done(done_na),
        .misaligned(mis_na), .bus_err(err_na),
        .data_addr(addr_na), .data_wr_data(wd_na), .data_mask(mask_na),
        .data_wr_en(wr_en_na), .data_req(req_na),
        .data_rd_data(rd_na), .data_ack(ack_na), .state_dbg(state_na)
    );

    // ---------------- memory model ----------------
    typedef struct {
        logic [31:0] addr;
        logic [3:0]  mask;
        logic [31:0] wdata;
        logic        we;
        logic        stable;
    } txn_t;

    logic [31:0] mem [logic [29:0]];
    txn_t        log_q[$];
    int          ack_lat = 1;
    logic        ack_on = 1'b1;
    int          wait_cnt = 0;
    int          rise_cnt = 0;
    logic        prev_req = 1'b0;
    logic        seed_en = 1'b0;
    logic [29:0] seed_idx = 30'h0;
    logic [31:0] seed_val = 32'h0;
    logic [29:0] m_idx;
    logic [31:0] m_cur;
    logic [31:0] f_addr, f_wd;
    logic [3:0]  f_mask;
    logic        f_stab;

    always @(posedge clk) begin
        if (seed_en) mem[seed_idx] = seed_val;
        if (data_req && !prev_req) rise_cnt = rise_cnt + 1;
        prev_req = data_req;
        if (data_ack) begin
            data_ack <= 1'b0;
        end else if (data_req && ack_on) begin
            if (wait_cnt == 0) begin
                f_addr = data_addr; f_mask = data_mask; f_wd = data_wr_data; f_stab = 1'b1;
            end else if (data_addr !== f_addr || data_mask !== f_mask || data_wr_data !== f_wd) begin
                f_stab = 1'b0;
            end
            if (wait_cnt + 1 >= ack_lat) begin
                m_idx = data_addr[31:2];
                m_cur = mem.exists(m_idx) ? mem[m_idx] : 32'h0;
                data_rd_data <= m_cur;
                if (data_wr_en) begin
                    for (int b = 0; b < 4; b++)
                        if (data_mask[b]) m_cur[8*b +: 8] = data_wr_data[8*b +: 8];
                    mem[m_idx] = m_cur;
                end
                log_q.push_back('{addr: data_addr, mask: data_mask, wdata: data_wr_data,
                                  we: data_wr_en, stable: f_stab});
                data_ack <= 1'b1;
                wait_cnt = 0;
            end else begin
                wait_cnt = wait_cnt + 1;
            end
        end else begin
            wait_cnt = 0;
        end
    end

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic seed(input logic [29:0] idx, input logic [31:0] val);
        seed_idx = idx;
        seed_val = val;
        seed_en  = 1'b1;
        tick();
        seed_en  = 1'b0;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  size;
        logic        uns;
        logic        st;
        int          lat;
        logic        seed;
        logic [29:0] s0i;
        logic [31:0] s0v;
        logic [29:0] s1i;
        logic [31:0] s1v;
        logic [31:0] exp_ld;
        int          n;
        logic [31:0] a0;
        logic [3:0]  m0;
        logic [31:0] d0;
        logic [31:0] a1;
        logic [3:0]  m1;
        logic [31:0] d1;
    } vec_t;

    function automatic vec_t mk(
        input logic [31:0] addr, input logic [31:0] wdata, input logic [1:0] size,
        input logic uns, input logic st, input int lat,
        input logic sd, input logic [29:0] s0i, input logic [31:0] s0v,
        input logic [29:0] s1i, input logic [31:0] s1v,
        input logic [31:0] exp_ld, input int n,
        input logic [31:0] a0, input logic [3:0] m0, input logic [31:0] d0,
        input logic [31:0] a1, input logic [3:0] m1, input logic [31:0] d1);
        vec_t v;
        v.addr = addr; v.wdata = wdata; v.size = size; v.uns = uns; v.st = st;
        v.lat = lat; v.seed = sd; v.s0i = s0i; v.s0v = s0v; v.s1i = s1i; v.s1v = s1v;
        v.exp_ld = exp_ld; v.n = n;
        v.a0 = a0; v.m0 = m0; v.d0 = d0; v.a1 = a1; v.m1 = m1; v.d1 = d1;
        return v;
    endfunction

    localparam int NV = 16;
    vec_t vt[NV];

    task automatic run_vec(input vec_t v, input int id);
        int   cyc;
        logic done;
        int   base;
        int   rbase;
        if (v.seed) begin
            seed(v.s0i, v.s0v);
            seed(v.s1i, v.s1v);
        end
        ack_lat = v.lat;
        base  = log_q.size();
        rbase = rise_cnt;
        chk($sformatf("v%0d_rdy", id), {31'h0, decode_rdy}, 32'd1);
        decode_addr = v.addr; decode_wdata = v.wdata; decode_size = v.size;
        decode_unsigned = v.uns; decode_load = !v.st; decode_store = v.st;
        decode_vld = 1'b1;
        tick();
        decode_vld = 1'b0; decode_load = 1'b0; decode_store = 1'b0;
        cyc  = 1;
        done = 1'b0;
        while (cyc < 40) begin
            if (lsu_done) begin
                done = 1'b1;
                break;
            end
            tick();
            cyc++;
        end
        chk($sformatf("v%0d_done", id), {31'h0, done}, 32'd1);
        chk($sformatf("v%0d_regwr", id), {31'h0, regwr_lsu}, {31'h0, !v.st});
        chk($sformatf("v%0d_buserr", id), {31'h0, bus_err}, 32'd0);
        if (!v.st) chk($sformatf("v%0d_ld", id), load_data, v.exp_ld);
        if (!v.st && v.n == 1) chk($sformatf("v%0d_lat", id), cyc, v.lat + 2);
        chk($sformatf("v%0d_ntxn", id), log_q.size() - base, v.n);
        chk($sformatf("v%0d_rises", id), rise_cnt - rbase, v.n);
        if (log_q.size() - base == v.n) begin
            for (int t = 0; t < v.n; t++) begin
                txn_t tx;
                tx = log_q[base + t];
                chk($sformatf("v%0d_t%0d_addr", id, t), tx.addr, (t == 0) ? v.a0 : v.a1);
                chk($sformatf("v%0d_t%0d_mask", id, t), {28'h0, tx.mask}, {28'h0, (t == 0) ? v.m0 : v.m1});
                chk($sformatf("v%0d_t%0d_we", id, t), {31'h0, tx.we}, {31'h0, v.st});
                chk($sformatf("v%0d_t%0d_stable", id, t), {31'h0, tx.stable}, 32'd1);
                if (v.st) chk($sformatf("v%0d_t%0d_wd", id, t), tx.wdata, (t == 0) ? v.d0 : v.d1);
            end
        end
        tick();
        chk($sformatf("v%0d_idle_done", id), {31'h0, lsu_done}, 32'd0);
        if (!v.st) chk($sformatf("v%0d_ld_hold", id), load_data, v.exp_ld);
    endtask

    // ---------------- main sequence ----------------
    int   reqc;
    int   cyc;
    int   lbase;
    logic saw_req;

    initial begin
        vt[0]  = mk(32'h40, 0, 2, 0, 0, 1, 1, 30'h10, 32'h89ABCDEF, 30'h11, 32'h445566BB,
                    32'h89ABCDEF, 1, 32'h40, 4'hF, 0, 0, 0, 0);
        vt[1]  = mk(32'h43, 0, 1, 0, 0, 1, 1, 30'h10, 32'hAA112233, 30'h11, 32'h445566BB,
                    32'hFFFFBBAA, 2, 32'h40, 4'h8, 0, 32'h44, 4'h1, 0);
        vt[2]  = mk(32'h43, 0, 1, 1, 0, 3, 0, 0, 0, 0, 0,
                    32'h0000BBAA, 2, 32'h40, 4'h8, 0, 32'h44, 4'h1, 0);
        vt[3]  = mk(32'h43, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0,
                    32'hFFFFFFAA, 1, 32'h40, 4'h8, 0, 0, 0, 0);
        vt[4]  = mk(32'h43, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0,
                    32'h000000AA, 1, 32'h40, 4'h8, 0, 0, 0, 0);
        vt[5]  = mk(32'h42, 0, 1, 0, 0, 3, 0, 0, 0, 0, 0,
                    32'hFFFFAA11, 1, 32'h40, 4'hC, 0, 0, 0, 0);
        vt[6]  = mk(32'h42, 0, 2, 0, 0, 1, 0, 0, 0, 0, 0,
                    32'h66BBAA11, 2, 32'h40, 4'hC, 0, 32'h44, 4'h3, 0);
        vt[7]  = mk(32'h41, 0, 2, 0, 0, 1, 0, 0, 0, 0, 0,
                    32'hBBAA1122, 2, 32'h40, 4'hE, 0, 32'h44, 4'h1, 0);
        vt[8]  = mk(32'h7E, 32'hDDCCBBAA, 2, 0, 1, 1, 1, 30'h1F, 32'h11111111, 30'h20, 32'h22222222,
                    0, 2, 32'h7C, 4'hC, 32'hBBAA0000, 32'h80, 4'h3, 32'h0000DDCC);
        vt[9]  = mk(32'h7C, 0, 2, 0, 0, 1, 0, 0, 0, 0, 0,
                    32'hBBAA1111, 1, 32'h7C, 4'hF, 0, 0, 0, 0);
        vt[10] = mk(32'h80, 0, 2, 0, 0, 1, 0, 0, 0, 0, 0,
                    32'h2222DDCC, 1, 32'h80, 4'hF, 0, 0, 0, 0);
        vt[11] = mk(32'h81, 32'h55, 0, 0, 1, 1, 0, 0, 0, 0, 0,
                    0, 1, 32'h80, 4'h2, 32'h00005500, 0, 0, 0);
        vt[12] = mk(32'h80, 0, 2, 0, 0, 1, 0, 0, 0, 0, 0,
                    32'h222255CC, 1, 32'h80, 4'hF, 0, 0, 0, 0);
        vt[13] = mk(32'h82, 32'h1234, 1, 0, 1, 3, 0, 0, 0, 0, 0,
                    0, 1, 32'h80, 4'hC, 32'h12340000, 0, 0, 0);
        vt[14] = mk(32'h82, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0,
                    32'h00001234, 1, 32'h80, 4'hC, 0, 0, 0, 0);
        vt[15] = mk(32'hFFFFFFFE, 0, 2, 0, 0, 1, 1, 30'h3FFFFFFF, 32'h12345678, 30'h0, 32'h9ABCDEF0,
                    32'hDEF01234, 2, 32'hFFFFFFFC, 4'hC, 0, 32'h0, 4'h3, 0);

        // Reset state
        repeat (3) tick();
        chk("rst_rdy", {31'h0, decode_rdy}, 32'd0);
        chk("rst_req", {31'h0, data_req}, 32'd0);
        chk("rst_addr", data_addr, 32'h0);
        chk("rst_mask", {28'h0, data_mask}, 32'h0);
        chk("rst_ld", load_data, 32'h0);
        chk("rst_pulses", {28'h0, regwr_lsu, lsu_done, misaligned, bus_err}, 32'h0);
        rstz = 1'b1;
        chk("rel_rdy_before_clk", {31'h0, decode_rdy}, 32'd0);
        tick();
        chk("rel_rdy_after_clk", {31'h0, decode_rdy}, 32'd1);

        // Neither load nor store: nothing happens
        decode_vld = 1'b1;
        decode_addr = 32'h40;
        tick();
        decode_vld = 1'b0;
        chk("nop_req", {31'h0, data_req}, 32'd0);
        chk("nop_rdy", {31'h0, decode_rdy}, 32'd1);
        chk("nop_state", {30'h0, state_dbg}, 32'd0);

        // Table-driven vectors
        for (int i = 0; i < NV; i++) run_vec(vt[i], i);

        // Timeout: no ack at all
        ack_on = 1'b0;
        decode_addr = 32'h40; decode_size = 2'd2; decode_unsigned = 1'b0;
        decode_load = 1'b1; decode_vld = 1'b1;
        tick();
        decode_vld = 1'b0; decode_load = 1'b0;
        reqc = 0;
        cyc  = 0;
        while (!lsu_done && cyc < 20) begin
            if (data_req) reqc++;
            tick();
            cyc++;
        end
        chk("tmo_req_cycles", reqc, 4);
        chk("tmo_done", {31'h0, lsu_done}, 32'd1);
        chk("tmo_buserr", {31'h0, bus_err}, 32'd1);
        chk("tmo_regwr", {31'h0, regwr_lsu}, 32'd0);
        chk("tmo_req_low", {31'h0, data_req}, 32'd0);
        chk("tmo_ld_hold", load_data, 32'hDEF01234);
        tick();
        chk("tmo_buserr_pulse", {31'h0, bus_err}, 32'd0);
        chk("tmo_idle", {31'h0, decode_rdy}, 32'd1);
        ack_on = 1'b1;

        // Misaligned rejection with splitting disabled
        chk("na_rdy", {31'h0, rdy_na}, 32'd1);
        decode_addr = 32'hFFFFFFFE; decode_size = 2'd2; decode_load = 1'b1;
        vld_na = 1'b1;
        tick();
        vld_na = 1'b0; decode_load = 1'b0;
        chk("na_mis_pulse", {31'h0, mis_na}, 32'd1);
        chk("na_req0", {31'h0, req_na}, 32'd0);
        saw_req = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            saw_req = saw_req | req_na;
        end
        chk("na_mis_clear", {31'h0, mis_na}, 32'd0);
        chk("na_no_req", {31'h0, saw_req}, 32'd0);
        chk("na_bus_idle", addr_na | wd_na | {28'h0, mask_na}, 32'h0);
        chk("na_flags", {27'h0, regwr_na, done_na, err_na, wr_en_na, rdy_na}, 32'h1);
        chk("na_ld", ld_na, 32'h0);
        chk("na_state", {30'h0, state_na}, 32'd0);
        // half at offset 3 is also rejected
        decode_addr = 32'h43; decode_size = 2'd1; decode_load = 1'b1;
        vld_na = 1'b1;
        tick();
        vld_na = 1'b0; decode_load = 1'b0;
        chk("na_half_mis", {31'h0, mis_na}, 32'd1);
        chk("na_half_req", {31'h0, req_na}, 32'd0);
        tick();

        // Reset in the middle of the second write of a split store
        seed(30'h1F, 32'h11111111);
        seed(30'h20, 32'h22222222);
        ack_lat = 1;
        lbase = log_q.size();
        decode_addr = 32'h7E; decode_wdata = 32'hDDCCBBAA; decode_size = 2'd2;
        decode_store = 1'b1; decode_vld = 1'b1;
        tick();
        decode_vld = 1'b0; decode_store = 1'b0;
        tick();
        tick();
        chk("mid_gap_req", {31'h0, data_req}, 32'd0);
        chk("mid_gap_state", {30'h0, state_dbg}, 32'd2);
        tick();
        chk("mid_req1_req", {31'h0, data_req}, 32'd1);
        rstz = 1'b0;
        #1;
        chk("mid_rst_req", {31'h0, data_req}, 32'd0);
        chk("mid_rst_bus", data_addr | data_wr_data | {27'h0, data_wr_en, data_mask}, 32'h0);
        chk("mid_rst_rdy", {31'h0, decode_rdy}, 32'd0);
        chk("mid_rst_ld", load_data, 32'h0);
        repeat (2) tick();
        rstz = 1'b1;
        chk("mid_rel_rdy0", {31'h0, decode_rdy}, 32'd0);
        tick();
        chk("mid_rel_rdy1", {31'h0, decode_rdy}, 32'd1);
        repeat (3) tick();
        chk("mid_one_txn", log_q.size() - lbase, 1);
        chk("mid_w20_untouched", mem[30'h20], 32'h22222222);
        chk("mid_w1f_written", mem[30'h1F], 32'hBBAA1111);
        chk("mid_idle_req", {31'h0, data_req}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
